// File: rtl/cdb_broadcast.sv
// rtl/cdb_broadcast.sv - completion FIFO feeding the W-wide common data bus
// Compacts up to N finished execute lanes per cycle and broadcasts up to W oldest entries.
module cdb_broadcast #(
  parameter int unsigned N     = 5,
  parameter int unsigned W     = 3,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned ROB_W = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  logic [N-1:0]               ex_done,
  input  logic [N-1:0][XLEN-1:0]     ex_result,
  input  logic [N-1:0][TAG_W-1:0]    ex_tag,
  input  logic [N-1:0][ROB_W-1:0]    ex_rob,
  output logic                       cp_ready,
  output logic [W-1:0]               cdb_valid,
  output logic [W-1:0][XLEN-1:0]     cdb_result,
  output logic [W-1:0][TAG_W-1:0]    cdb_tag,
  output logic [W-1:0][ROB_W-1:0]    cdb_rob
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
    logic [ROB_W-1:0] rob;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] npush, npop;

  // Offsets never exceed DEPTH, so one conditional subtract gives the modulo.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  always_comb begin
    mem_d      = mem_q;
    npush      = '0;
    cdb_valid  = '0;
    cdb_result = '0;
    cdb_tag    = '0;
    cdb_rob    = '0;
    cp_ready   = (count_q <= CNT_W'(DEPTH - N));

    if (cp_ready && !squash) begin
      for (int i = 0; i < N; i++) begin
        if (ex_done[i]) begin
          mem_d[ptr_add(tail_q, 32'(npush))] = '{result: ex_result[i], tag: ex_tag[i], rob: ex_rob[i]};
          npush = npush + 1'b1;
        end
      end
    end

    npop = (count_q < CNT_W'(W)) ? count_q : CNT_W'(W);

    // The bus never stalls, so every slot driven here is retired at the next edge.
    for (int k = 0; k < W; k++) begin
      if (CNT_W'(k) < npop) begin
        cdb_valid[k]  = 1'b1;
        cdb_result[k] = mem_q[ptr_add(head_q, k)].result;
        cdb_tag[k]    = mem_q[ptr_add(head_q, k)].tag;
        cdb_rob[k]    = mem_q[ptr_add(head_q, k)].rob;
      end
    end

    head_d  = ptr_add(head_q, 32'(npop));
    tail_d  = ptr_add(tail_q, 32'(npush));
    count_d = count_q + npush - npop;
  end

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_cdb_broadcast.sv
// tb/tb_cdb_broadcast.sv - directed self-checking bench for cdb_broadcast
// Drives inputs and samples outputs 1 time unit after the rising edge.
module tb_cdb_broadcast;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 squash;
  logic [4:0]           ex_done;
  logic [4:0][31:0]     ex_result;
  logic [4:0][5:0]      ex_tag;
  logic [4:0][4:0]      ex_rob;
  logic                 cp_ready;
  logic [2:0]           cdb_valid;
  logic [2:0][31:0]     cdb_result;
  logic [2:0][5:0]      cdb_tag;
  logic [2:0][4:0]      cdb_rob;

  int n_cmp = 0;
  int n_bad = 0;

  cdb_broadcast #(.N(5), .W(3), .DEPTH(8), .XLEN(32), .TAG_W(6), .ROB_W(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .squash     (squash),
    .ex_done    (ex_done),
    .ex_result  (ex_result),
    .ex_tag     (ex_tag),
    .ex_rob     (ex_rob),
    .cp_ready   (cp_ready),
    .cdb_valid  (cdb_valid),
    .cdb_result (cdb_result),
    .cdb_tag    (cdb_tag),
    .cdb_rob    (cdb_rob)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    ex_done   = '0;
    ex_result = '0;
    ex_tag    = '0;
    ex_rob    = '0;
  endtask

  task automatic set_lane(input int i, input logic [31:0] r, input logic [5:0] t, input logic [4:0] rb);
    ex_done[i]   = 1'b1;
    ex_result[i] = r;
    ex_tag[i]    = t;
    ex_rob[i]    = rb;
  endtask

  task automatic load_group(input logic [5:0] t0);
    clear_in();
    for (int i = 0; i < 5; i++) set_lane(i, 32'(100 + i), 6'(t0 + 6'(i)), 5'(i));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 64'(cdb_valid), 64'h0);
    check({tag, "_payload"}, {61'h0, |cdb_result, |cdb_tag, |cdb_rob}, 64'h0);
    check({tag, "_ready"}, 64'(cp_ready), 64'h1);
  endtask

  int          q[$];
  int          sent;
  int          recvd;
  int          exp_pop;
  logic [2:0]  exp_v;
  logic [5:0]  t;
  bit          model_ready;

  initial begin
    reset  = 1'b1;
    squash = 1'b0;
    clear_in();
    step();
    step();
    reset = 1'b0;
    check_idle("reset");

    // Basic drain
    set_lane(0, 32'd50, 6'd1, 5'd0);
    set_lane(1, 32'd90, 6'd2, 5'd1);
    set_lane(2, 32'd13, 6'd3, 5'd2);
    set_lane(3, 32'd7, 6'd4, 5'd3);
    set_lane(4, 32'hA000_0000, 6'd5, 5'd4);
    step();
    clear_in();
    check("drain1_valid", 64'(cdb_valid), 64'h7);
    check("drain1_res0", 64'(cdb_result[0]), 64'd50);
    check("drain1_res1", 64'(cdb_result[1]), 64'd90);
    check("drain1_res2", 64'(cdb_result[2]), 64'd13);
    check("drain1_tags", 64'({cdb_tag[2], cdb_tag[1], cdb_tag[0]}), 64'({6'd3, 6'd2, 6'd1}));
    check("drain1_robs", 64'({cdb_rob[2], cdb_rob[1], cdb_rob[0]}), 64'({5'd2, 5'd1, 5'd0}));
    check("drain1_ready", 64'(cp_ready), 64'h0);
    step();
    check("drain2_valid", 64'(cdb_valid), 64'h3);
    check("drain2_res0", 64'(cdb_result[0]), 64'd7);
    check("drain2_res1", 64'(cdb_result[1]), 64'hA000_0000);
    check("drain2_res2_zero", 64'(cdb_result[2]), 64'h0);
    check("drain2_tags", 64'({cdb_tag[1], cdb_tag[0]}), 64'({6'd5, 6'd4}));
    check("drain2_ready", 64'(cp_ready), 64'h1);
    step();
    check_idle("drain3");

    // Sparse lanes
    set_lane(2, 32'd10, 6'd7, 5'd9);
    set_lane(4, 32'd1000, 6'd9, 5'd11);
    step();
    clear_in();
    check("sparse_valid", 64'(cdb_valid), 64'h3);
    check("sparse_res0", 64'(cdb_result[0]), 64'd10);
    check("sparse_res1", 64'(cdb_result[1]), 64'd1000);
    check("sparse_tags", 64'({cdb_tag[1], cdb_tag[0]}), 64'({6'd9, 6'd7}));
    check("sparse_robs", 64'({cdb_rob[1], cdb_rob[0]}), 64'({5'd11, 5'd9}));
    step();
    check_idle("sparse_end");

    // Backpressure: group 2 is held on the inputs while cp_ready is low
    load_group(6'd10);
    step();
    load_group(6'd20);
    check("bp1_ready", 64'(cp_ready), 64'h0);
    check("bp1_valid", 64'(cdb_valid), 64'h7);
    check("bp1_tags", 64'({cdb_tag[2], cdb_tag[1], cdb_tag[0]}), 64'({6'd12, 6'd11, 6'd10}));
    step();
    check("bp2_ready", 64'(cp_ready), 64'h1);
    check("bp2_valid", 64'(cdb_valid), 64'h3);
    check("bp2_tags", 64'({cdb_tag[1], cdb_tag[0]}), 64'({6'd14, 6'd13}));
    step();
    clear_in();
    check("bp3_ready", 64'(cp_ready), 64'h0);
    check("bp3_valid", 64'(cdb_valid), 64'h7);
    check("bp3_tags", 64'({cdb_tag[2], cdb_tag[1], cdb_tag[0]}), 64'({6'd22, 6'd21, 6'd20}));
    step();
    check("bp4_valid", 64'(cdb_valid), 64'h3);
    check("bp4_tags", 64'({cdb_tag[1], cdb_tag[0]}), 64'({6'd24, 6'd23}));
    step();
    check_idle("bp_end");

    // Wrap-around streaming against a reference queue
    sent  = 0;
    recvd = 0;
    q.delete();
    for (int cyc = 0; cyc < 80 && !(sent == 40 && q.size() == 0); cyc++) begin
      clear_in();
      model_ready = (q.size() <= 3);
      check("wrap_ready", 64'(cp_ready), 64'(model_ready));
      exp_pop = (q.size() < 3) ? q.size() : 3;
      exp_v   = 3'((1 << exp_pop) - 1);
      check("wrap_valid", 64'(cdb_valid), 64'(exp_v));
      for (int k = 0; k < exp_pop; k++) begin
        check("wrap_tag", 64'(cdb_tag[k]), 64'(q.pop_front()));
        recvd++;
      end
      if (model_ready && sent < 40) begin
        t = 6'((sent + 40) % 64);
        set_lane(sent % 5, 32'(sent * 3), t, 5'(sent % 32));
        q.push_back(int'(t));
        sent++;
      end
      step();
    end
    clear_in();
    check("wrap_sent", 64'(sent), 64'd40);
    check("wrap_recvd", 64'(recvd), 64'd40);
    check_idle("wrap_end");

    // Squash with 4 queued; the squash-cycle bus still shows the old FIFO
    clear_in();
    for (int i = 0; i < 4; i++) set_lane(i, 32'(200 + i), 6'(40 + i), 5'(i));
    step();
    load_group(6'd50);
    squash = 1'b1;
    check("sq_pre_valid", 64'(cdb_valid), 64'h7);
    check("sq_pre_tags", 64'({cdb_tag[2], cdb_tag[1], cdb_tag[0]}), 64'({6'd42, 6'd41, 6'd40}));
    step();
    squash = 1'b0;
    clear_in();
    check_idle("sq_post");
    step();
    check_idle("sq_post2");

    // Squash while ready: the group on the inputs must be dropped
    set_lane(1, 32'd300, 6'd60, 5'd1);
    set_lane(3, 32'd301, 6'd61, 5'd2);
    step();
    load_group(6'd30);
    squash = 1'b1;
    check("sq2_pre_ready", 64'(cp_ready), 64'h1);
    check("sq2_pre_tags", 64'({cdb_tag[1], cdb_tag[0]}), 64'({6'd61, 6'd60}));
    step();
    squash = 1'b0;
    clear_in();
    check_idle("sq2_post");
    step();
    check_idle("sq2_post2");

    // Reset mid-operation, asserted together with squash and a live group
    load_group(6'd1);
    step();
    load_group(6'd33);
    reset  = 1'b1;
    squash = 1'b1;
    step();
    reset  = 1'b0;
    squash = 1'b0;
    clear_in();
    check_idle("rst_mid");
    step();
    check_idle("rst_mid2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdb_broadcast.md
# cdb_broadcast

Completion-side consumer of the N-way execute stage. Each cycle it accepts up to N finished results from the ALU and multiplier lanes and holds them in a circular FIFO. It broadcasts up to W of them per cycle on the common data bus (CDB) to the reservation stations, physical register file and ROB. When there is no room for a full N-wide group it asserts backpressure, so execute lanes hold their results.

## Interface
- `N`, 5: execute lanes feeding the block.
- `W`, 3: CDB broadcast lanes per cycle, with 1 ≤ W ≤ N.
- `DEPTH`, 8: FIFO entries, with DEPTH ≥ N.
- `XLEN`, 32: result width.
- `TAG_W`, 6: physical-register tag width.
- `ROB_W`, 5: ROB index width.
- `clock  in  1`: single clock. All state updates on the rising edge.
- `reset  in  1`: synchronous, active-high.
- `squash  in  1`: synchronous flush on branch mispredict.
- `ex_done  in  [N-1:0]`: lane i holds a finished result.
- `ex_result  in  [N-1:0][XLEN-1:0]`: lane result.
- `ex_tag  in  [N-1:0][TAG_W-1:0]`: destination physical tag.
- `ex_rob  in  [N-1:0][ROB_W-1:0]`: ROB index.
- `cp_ready  out  1`: block can accept a full N-wide group this cycle.
- `cdb_valid  out  [W-1:0]`: broadcast slot valid.
- `cdb_result  out  [W-1:0][XLEN-1:0]`: broadcast result.
- `cdb_tag  out  [W-1:0][TAG_W-1:0]`: broadcast tag.
- `cdb_rob  out  [W-1:0][ROB_W-1:0]`: broadcast ROB index.

## Operation
- State:
  - entry array `[DEPTH]` of {result, tag, rob};
  - `head`, `tail` pointers, each `$clog2(DEPTH)` bits, wrapping modulo DEPTH, so DEPTH need not be a power of two;
  - `count`, `$clog2(DEPTH+1)` bits.
- `cp_ready = (count <= DEPTH-N)`. This is combinational from the registered count only; it never depends on this cycle's pops.
- Push: when `cp_ready && !squash`, every lane with `ex_done[i]=1` is written.
  - Lanes are compacted in ascending lane index into `tail`, `tail+1`, … (mod DEPTH).
  - `npush = popcount(ex_done)`.
  - Lanes with `ex_done=0` consume no entry.
- When `cp_ready=0`, inputs are ignored. Execute lanes are required to hold `ex_done` and payload until a cycle with `cp_ready=1`.
- Broadcast:
  - `npop = min(count, W)`.
  - Slot k (k < npop) drives entry `head+k` (mod DEPTH) with `cdb_valid[k]=1`.
  - Slots k ≥ npop have `cdb_valid=0`, and their payload fields drive 0.
  - The CDB never stalls: every valid slot is consumed at the next edge, and `head` advances by `npop`.
- Outputs are a combinational read of the FIFO head plus registered state. Results written at an edge are visible no earlier than the following cycle; there is no same-cycle bypass.
- Ordering:
  - FIFO order across cycles.
  - Ascending lane index within one input group.
  - Slot 0 is always the oldest.
- Count update: `count_next = count + npush - npop`. Push and pop happen in the same cycle.
- Overflow is impossible by construction: count ≤ DEPTH-N before a push, and the push is at most N.
- Underflow is impossible: npop ≤ count.
- Squash:
  - At the edge where `squash=1`, head, tail and count clear to 0.
  - That cycle's inputs are dropped.
  - The cdb outputs in the squash cycle itself still reflect the pre-squash FIFO (the ROB filters them).
- Reset: same clearing as squash. Reset has priority over squash.

## Timing
- Reset values, from the cycle after reset is sampled high:
  - `count=0`, `head=0`, `tail=0`;
  - `cdb_valid=0`, all cdb payload 0;
  - `cp_ready=1`.
- Latency: a result accepted at edge t appears on the CDB in the cycle after edge t at the earliest (1 cycle), and later if older entries are queued ahead of it.
- Throughput: W results per cycle sustained.
- Backpressure: `cp_ready` deasserts in the cycle where `count > DEPTH-N`. It reasserts in the cycle after pops bring `count` back to ≤ DEPTH-N.
- Wrap: pointers roll from DEPTH-1 to 0 with no bubble.

## Test plan
- **Basic drain, W=3, DEPTH=8.** After reset, one edge with N=5 lanes done: results 50, 90, 13, 7, 0xA0000000, tags 1..5.
  - Next cycle: cdb = {50, 90, 13}, valid=3'b111.
  - Cycle after: {7, 0xA0000000}, valid=3'b011.
  - Then valid=0.
- **Sparse lanes.** `ex_done=5'b10100` with results 10 (lane 2) and 1000 (lane 4).
  - Next cycle: slot0=10, slot1=1000, valid=3'b011.
- **Backpressure.** Two consecutive full groups.
  - After the first push, count=5 > 3, so `cp_ready=0`. The second group is held, not written.
  - After one pop, count=2 and `cp_ready=1`. The second group is accepted.
  - Broadcast order is strictly group 1 then group 2, with tags verified.
- **Wrap-around.** Stream 40 one-lane results with tags incrementing mod 64.
  - CDB tags emerge in order with no loss or duplication across pointer wrap.
  - count never exceeds 8.
- **Squash mid-stream.** Squash with 4 entries queued and a new group on the inputs.
  - Next cycle: `cdb_valid=0`, count=0, `cp_ready=1`. The dropped group never appears.
- **Reset mid-operation.** Same as squash, and additionally all outputs match the reset values above.
